// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front-end: FSM state, FIFO entry,
// PC step and the redirect alignment helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    STALL   = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [63:0] PC_INC = 64'd4;

  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return {pc[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Shift-register FIFO of fetched {pc, instr} pairs; entry 0 is always the head,
// so the head presented downstream comes straight out of a register.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  fetch_entry_t  i_data,
  input  logic          i_pop,
  output logic [CW-1:0] o_count,
  output logic          o_valid,
  output fetch_entry_t  o_head
);

  fetch_entry_t  r_mem [DEPTH];
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic [CW-1:0] w_wr_pos;
  logic [AW-1:0] w_wr_idx;

  assign w_pop    = i_pop && (r_count != '0);
  assign w_wr_pos = r_count - CW'(w_pop);
  assign w_wr_idx = w_wr_pos[AW-1:0];

  // The push lands one slot lower when the same edge shifts the queue down.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
      end
      if (i_push) r_mem[w_wr_idx] <= i_data;
      r_count <= r_count + CW'(i_push) - CW'(w_pop);
    end
  end

  assign o_count = r_count;
  assign o_valid = (r_count != '0);
  assign o_head  = r_mem[0];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(i_push && !i_flush && (r_count == CW'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetcher: one outstanding imem request at a time,
// responses buffered in fetch_fifo, flush and refetch on branch redirect.
//
// state   | meaning
// IDLE    | first cycle after reset release
// REQ     | request outstanding at r_fetch_pc
// STALL   | FIFO full, no request
// DISCARD | stale request outstanding; its data is dropped, then refetch r_pend_pc
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
);

  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_t  r_state, w_state_nxt;
  logic [63:0]   r_fetch_pc, r_pend_pc, w_target;
  logic [CW-1:0] w_count, w_count_nxt;
  logic          w_push, w_pop, w_fifo_valid, w_acked;
  fetch_entry_t  w_push_data, w_head;

  assign w_target    = align_pc(redirect_pc);
  assign w_acked     = imem_req && imem_ack;
  // A redirect flushes the FIFO, so it also suppresses this cycle's push and pop.
  assign w_push      = (r_state == REQ) && imem_ack && !redirect_valid;
  assign w_pop       = out_ready && !redirect_valid;
  assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop && w_fifo_valid);
  assign w_push_data = '{pc: r_fetch_pc, instr: imem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_count (w_count),
    .o_valid (w_fifo_valid),
    .o_head  (w_head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = REQ;
      REQ: begin
        if (redirect_valid)  w_state_nxt = imem_ack ? REQ : DISCARD;
        else if (imem_ack)   w_state_nxt = (w_count_nxt < FULL) ? REQ : STALL;
      end
      STALL: begin
        if (redirect_valid || (w_count < FULL)) w_state_nxt = REQ;
      end
      DISCARD: begin
        if (imem_ack) w_state_nxt = REQ;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req = (r_state == REQ) || (r_state == DISCARD);
  end

  // While a stale request is in flight the address must not move, so the
  // redirect target waits in r_pend_pc until that request is acknowledged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_pend_pc  <= RESET_PC;
    end else if (redirect_valid) begin
      if (imem_req && !imem_ack) r_pend_pc  <= w_target;
      else                       r_fetch_pc <= w_target;
    end else if (w_acked) begin
      r_fetch_pc <= (r_state == DISCARD) ? r_pend_pc : r_fetch_pc + PC_INC;
    end
  end

  assign imem_addr = r_fetch_pc;
  assign out_valid = w_fifo_valid;
  assign out_pc    = w_head.pc;
  assign out_instr = w_head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a transaction-level model of fetch order, redirects and buffering.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_ready      (out_ready)
  );

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return a[31:0] ^ 32'h5A3C_0F1E ^ {a[63:48], a[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_ack = 1'b0;
    imem_rdata = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Memory responder: waits (bounded) for a request, acks it after lat cycles.
  task automatic serve(input int lat, output logic [63:0] a, output bit got);
    got = 1'b0;
    a = '0;
    for (int i = 0; i < 12 && !got; i++) begin
      if (imem_req === 1'b1) got = 1'b1;
      else tick();
    end
    if (got) begin
      a = imem_addr;
      repeat (lat) tick();
      imem_ack = 1'b1;
      imem_rdata = word_at(a);
      tick();
      imem_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({imem_req, imem_addr, out_valid, out_pc, out_instr} !== '0)
      $display("FAIL reset_state: req=%b addr=%h valid=%b pc=%h instr=%h, want all zero",
               imem_req, imem_addr, out_valid, out_pc, out_instr);
    else n_pass++;
    rst = 1'b1;
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL idle_cycle: req=%b want 0", imem_req);
    else n_pass++;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0)
      $display("FAIL first_req: req=%b addr=%h want 1/0", imem_req, imem_addr);
    else n_pass++;
  endtask

  task automatic test_sequential();
    logic [63:0] exp;
    apply_reset();
    out_ready = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      exp = 64'(k) * 4;
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp)
        $display("FAIL seq_addr: req=%b addr=%h want 1/%h", imem_req, imem_addr, exp);
      else n_pass++;
      tick();
      imem_ack = 1'b1;
      imem_rdata = word_at(exp);
      tick();
      imem_ack = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== exp || out_instr !== word_at(exp))
        $display("FAIL seq_out: valid=%b pc=%h instr=%h want 1/%h/%h",
                 out_valid, out_pc, out_instr, exp, word_at(exp));
      else n_pass++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    int n;
    apply_reset();
    n = 0;
    tick();
    for (int i = 0; i < 8; i++) begin
      if (imem_req === 1'b1) begin
        n_checks++;
        if (imem_addr !== 64'(n) * 4)
          $display("FAIL stall_addr: addr=%h want %h", imem_addr, 64'(n) * 4);
        else n_pass++;
        n++;
        imem_ack = 1'b1;
        imem_rdata = word_at(imem_addr);
      end else begin
        imem_ack = 1'b0;
      end
      tick();
    end
    imem_ack = 1'b0;
    n_checks++;
    if (n != DEPTH || imem_req !== 1'b0)
      $display("FAIL stall_count: requests=%0d req=%b want %0d/0", n, imem_req, DEPTH);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h0)
      $display("FAIL stall_head: valid=%b pc=%h want 1/0", out_valid, out_pc);
    else n_pass++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h4 || out_instr !== word_at(64'h4))
      $display("FAIL stall_pop_head: valid=%b pc=%h want 1/4", out_valid, out_pc);
    else n_pass++;
    for (int i = 0; i < 3 && imem_req !== 1'b1; i++) tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h10)
      $display("FAIL stall_resume: req=%b addr=%h want 1/10", imem_req, imem_addr);
    else n_pass++;
  endtask

  task automatic test_discard();
    logic [63:0] a;
    bit got;
    apply_reset();
    out_ready = 1'b1;
    serve(0, a, got);
    serve(0, a, got);
    n_checks++;
    if (!got || a !== 64'h4) $display("FAIL disc_pre: addr=%h seen=%0b want 4", a, got);
    else n_pass++;
    redirect_valid = 1'b1;
    redirect_pc = 64'h100;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h8 || out_valid !== 1'b0)
        $display("FAIL disc_hold: req=%b addr=%h valid=%b want 1/8/0",
                 imem_req, imem_addr, out_valid);
      else n_pass++;
      if (i < 2) tick();
    end
    imem_ack = 1'b1;
    imem_rdata = word_at(64'h8);
    tick();
    imem_ack = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL disc_drop: valid=%b want 0", out_valid);
    else n_pass++;
    serve(0, a, got);
    n_checks++;
    if (!got || a !== 64'h100) $display("FAIL disc_target: addr=%h seen=%0b want 100", a, got);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h100)
      $display("FAIL disc_out: valid=%b pc=%h want 1/100", out_valid, out_pc);
    else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_redirect_ack();
    logic [63:0] a;
    bit got;
    apply_reset();
    out_ready = 1'b1;
    serve(0, a, got);
    tick();
    imem_ack = 1'b1;
    imem_rdata = word_at(64'h4);
    redirect_valid = 1'b1;
    redirect_pc = 64'h200;
    tick();
    imem_ack = 1'b0;
    redirect_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h200)
      $display("FAIL rack_next: valid=%b req=%b addr=%h want 0/1/200",
               out_valid, imem_req, imem_addr);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL rack_dropped: valid=%b want 0", out_valid);
    else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_discard();
    logic [63:0] a;
    bit got;
    apply_reset();
    serve(0, a, got);
    redirect_valid = 1'b1;
    redirect_pc = 64'h300;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h4)
      $display("FAIL rd_discarding: req=%b addr=%h want 1/4", imem_req, imem_addr);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0 || imem_addr !== 64'h0)
      $display("FAIL rd_async: req=%b valid=%b addr=%h want 0/0/0",
               imem_req, out_valid, imem_addr);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL rd_idle: req=%b want 0", imem_req);
    else n_pass++;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0)
      $display("FAIL rd_restart: req=%b addr=%h want 1/0", imem_req, imem_addr);
    else n_pass++;
  endtask

  task automatic test_align_wrap();
    logic [63:0] a;
    bit got;
    apply_reset();
    out_ready = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 64'h103;
    imem_ack = 1'b1;
    imem_rdata = word_at(64'h0);
    tick();
    redirect_valid = 1'b0;
    imem_ack = 1'b0;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h100)
      $display("FAIL align: req=%b addr=%h want 1/100", imem_req, imem_addr);
    else n_pass++;
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    serve(1, a, got);
    n_checks++;
    if (!got || a !== 64'h100) $display("FAIL wrap_old: addr=%h seen=%0b want 100", a, got);
    else n_pass++;
    serve(0, a, got);
    n_checks++;
    if (!got || a !== 64'hFFFF_FFFF_FFFF_FFFC)
      $display("FAIL wrap_last: addr=%h seen=%0b want fffffffffffffffc", a, got);
    else n_pass++;
    serve(0, a, got);
    n_checks++;
    if (!got || a !== 64'h0) $display("FAIL wrap_zero: addr=%h seen=%0b want 0", a, got);
    else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_flush_full();
    logic [63:0] a;
    bit got;
    apply_reset();
    tick();
    for (int i = 0; i < 8; i++) begin
      imem_ack = (imem_req === 1'b1);
      imem_rdata = word_at(imem_addr);
      tick();
    end
    imem_ack = 1'b0;
    n_checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL ff_full: req=%b valid=%b want 0/1", imem_req, out_valid);
    else n_pass++;
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h400;
    tick();
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h400)
      $display("FAIL ff_flush: valid=%b req=%b addr=%h want 0/1/400",
               out_valid, imem_req, imem_addr);
    else n_pass++;
    serve(0, a, got);
    n_checks++;
    if (!got || out_valid !== 1'b1 || out_pc !== 64'h400)
      $display("FAIL ff_head: valid=%b pc=%h seen=%0b want 1/400", out_valid, out_pc, got);
    else n_pass++;
  endtask

  // Model: a fetch stream that advances by 4 per kept response, restarts at the
  // aligned target on redirect; any response whose request saw a redirect is dropped.
  task automatic test_random();
    logic [95:0] sb[$];
    logic [63:0] exp_next, txn_addr, addr_s, tgt;
    logic [95:0] out_s;
    logic        req_s, ov_s;
    logic [31:0] rd;
    bit          txn, poison, rdir, rdy, ack;
    int          lat, idle_run;
    apply_reset();
    exp_next = 64'h0;
    txn = 1'b0;
    poison = 1'b0;
    lat = 0;
    idle_run = 0;
    for (int c = 0; c < 3000; c++) begin
      req_s = imem_req;
      addr_s = imem_addr;
      ov_s = out_valid;
      out_s = {out_pc, out_instr};
      n_checks++;
      if (ov_s !== (sb.size() != 0))
        $display("FAIL rnd_valid: cycle %0d valid=%b want %0d", c, ov_s, sb.size() != 0);
      else n_pass++;
      if (sb.size() != 0) begin
        n_checks++;
        if (out_s !== sb[0]) $display("FAIL rnd_head: cycle %0d got %h want %h", c, out_s, sb[0]);
        else n_pass++;
      end
      if (txn) begin
        n_checks++;
        if (req_s !== 1'b1 || addr_s !== txn_addr)
          $display("FAIL rnd_hold: cycle %0d req=%b addr=%h want 1/%h", c, req_s, addr_s, txn_addr);
        else n_pass++;
      end else if (req_s === 1'b1) begin
        n_checks++;
        if (addr_s !== exp_next)
          $display("FAIL rnd_addr: cycle %0d addr=%h want %h", c, addr_s, exp_next);
        else n_pass++;
        txn = 1'b1;
        txn_addr = addr_s;
        poison = 1'b0;
        lat = $urandom_range(0, 3);
      end
      if (req_s === 1'b1) begin
        n_checks++;
        if (sb.size() >= DEPTH)
          $display("FAIL rnd_credit: cycle %0d request with %0d buffered", c, sb.size());
        else n_pass++;
      end
      idle_run = (req_s !== 1'b1 && sb.size() < DEPTH) ? idle_run + 1 : 0;
      n_checks++;
      if (idle_run > 1) $display("FAIL rnd_stall_exit: cycle %0d idle for %0d cycles with room", c, idle_run);
      else n_pass++;

      ack = txn && (lat == 0);
      if (txn && lat > 0) lat--;
      rdy = ($urandom_range(0, 3) != 0);
      rdir = ($urandom_range(0, 15) == 0);
      tgt = 64'h1000 + 64'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      rd = $urandom;
      imem_ack = ack;
      imem_rdata = rd;
      out_ready = rdy;
      redirect_valid = rdir;
      redirect_pc = tgt;

      if (rdir) begin
        if (txn) poison = 1'b1;
        sb.delete();
        exp_next = {tgt[63:2], 2'b00};
      end else if (rdy && sb.size() != 0) begin
        void'(sb.pop_front());
      end
      if (ack) begin
        txn = 1'b0;
        if (!poison) begin
          sb.push_back({txn_addr, rd});
          exp_next = txn_addr + 64'd4;
        end
      end
      tick();
    end
    imem_ack = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_discard();
    test_redirect_ack();
    test_reset_discard();
    test_align_wrap();
    test_flush_full();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
